pe_pipe_acc: RTL and testbench
==============================

// Module: pe_pipe_acc
// PURPOSE
// - Pipelined, parametrised processing element. Next generation of the 32b combinational PE.
// - Element-wise add/sub/mul/multiply-add/shift/logic ops with optional signed saturation.
// - Adds a valid/ready stream interface, a fixed 3-stage pipeline and an internal
//   reduction accumulator (sum over a beat stream, emitted on the last beat).
// - Sits between the vector operand fetch and the register-file writeback in the lane datapath.
// PARAMETERS
// - DATA_W   32  Element container width; legal values are 32 or 64.
// - ACC_W    48  Reduction accumulator width; must be >= DATA_W+1. Guard bits for long sums.
// PORTS
// - clk           in   1        Clock; all state changes on the rising edge.
// - n_reset       in   1        Asynchronous active-low reset.
// - in_valid      in   1        Input beat valid.
// - in_ready      out  1        PE can accept a beat this cycle.
// - a, b, c       in   DATA_W   Operands: a=vs2, b=vs1, c=vd (accumulate addend).
// - op            in   pe_arith_op_t          Arithmetic op, sampled with the beat.
// - vsew          in   2        Element width: 0=8b, 1=16b, 2=32b, 3=64b (DATA_W=64 only).
// - mul_us        in   2        [1]=a unsigned, [0]=b unsigned for multiplies.
// - saturate_mode in   pe_saturation_mode_t   NONE / LOWER / UPPER (fractional multiply).
// - red_en        in   1        Beat is part of a reduction; sum a into the accumulator.
// - red_last      in   1        Final reduction beat; qualified by red_en.
// - out_valid     out  1        Result valid.
// - out_ready     in   1        Downstream accepts the result.
// - out           out  DATA_W   Result, zero-extended above the element width.
// - sat_flag      out  1        Result was clamped; valid with out_valid (feeds vxsat).
// BEHAVIOUR
// - Reset: out_valid=0, out=0, sat_flag=0, all stage valids=0, accumulator=0. in_ready=1 after reset.
// - Transfer in: in_valid&&in_ready. Transfer out: out_valid&&out_ready.
// - Pipeline: S1 captures and sign-extends operands to vsew. S2 runs the arithmetic, then the
//   multiplier, then the adder. S3 saturates and registers the output.
// - Latency: exactly 3 cycles from input transfer to out_valid when not stalled.
// - Stall: global enable en = !out_valid || out_ready. in_ready = en. All stages hold when en=0.
//   Throughput is 1 beat per cycle when out_ready is held high.
// - Arithmetic: add/sub are computed 1 bit wider than the element.
//   - Saturation clamps to signed [-2^(SEW-1), 2^(SEW-1)-1] and sets sat_flag.
//   - PE_SAT_UPPER multiply takes product bits [2*SEW-2:SEW-1] before the clamp.
//   - Shifts use b[log2(SEW)-1:0] only.
//   - Unsupported op: result 0, sat_flag 0.
// - Reduction (red_en=1, op ignored):
//   - Each beat adds sign-extended a to the accumulator in S2 (add is wrap-free to ACC_W).
//   - Non-last beats produce no output beat.
//   - The red_last beat emits acc+a, saturated to SEW when saturate_mode!=NONE, otherwise
//     truncated to SEW. The accumulator clears in the same cycle.
// - A non-reduction beat between reduction beats passes through normally and leaves the
//   accumulator intact.
// - red_last without red_en is ignored.
// - Stall during a reduction: the accumulator updates only when the beat advances out of S2.
// - Reset mid-operation: all in-flight beats are discarded, the accumulator clears,
//   and no partial output is produced.
// CONFIGURATION
// - PE_RELU_EN defined: adds input relu_en (1 bit, sampled with the beat).
//   - When relu_en=1, S3 replaces any negative (signed, SEW) final result with 0.
//   - ReLU applies after saturation; sat_flag is unaffected.
// - PE_RELU_EN undefined: no relu_en port; results pass unmodified.
// TESTING
// - 8b add, saturation on, a=0x7F, b=0x01 -> out=0x0000007F and sat_flag=1, 3 cycles after input.
// - 32b MUL, mul_us=2'b00, a=-3, b=7 -> out=0xFFFFFFEB, sat_flag=0.
// - 16b fractional MUL with PE_SAT_UPPER, a=b=0x8000 -> out=0x00007FFF, sat_flag=1.
// - Reduction: 4 beats a=10,20,30,40, red_last on beat 4 -> exactly one output, out=100.
//   A second reduction then starts from 0.
// - Backpressure: stream 6 beats with out_ready low for cycles 2-5 -> in_ready drops,
//   all 6 results appear in order with none lost or duplicated.
// - Assert n_reset during a 3-beat reduction, then a single red_last beat a=5 -> out=5.
//   With PE_RELU_EN, relu_en=1 and an add result of -4 -> out=0.

Source files
------------

// File: rtl/pe_pipe_acc_if.sv
// Shared op/saturation types and the valid/ready stream interface of pe_pipe_acc.
// Optional relu_en lane exists only when PE_RELU_EN is defined.
package pe_pipe_acc_pkg;
    typedef enum logic [3:0] {
        PE_ADD  = 4'd0,
        PE_SUB  = 4'd1,
        PE_MUL  = 4'd2,
        PE_MADD = 4'd3,
        PE_SLL  = 4'd4,
        PE_SRL  = 4'd5,
        PE_SRA  = 4'd6,
        PE_AND  = 4'd7,
        PE_OR   = 4'd8,
        PE_XOR  = 4'd9,
        PE_RSVD = 4'd15
    } pe_arith_op_t;

    typedef enum logic [1:0] {
        PE_SAT_NONE  = 2'd0,
        PE_SAT_LOWER = 2'd1,
        PE_SAT_UPPER = 2'd2
    } pe_saturation_mode_t;
endpackage

interface pe_pipe_acc_if import pe_pipe_acc_pkg::*; #(parameter int DATA_W = 32);
    logic                in_valid;
    logic                in_ready;
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
    logic [DATA_W-1:0]   c;
    pe_arith_op_t        op;
    logic [1:0]          vsew;
    logic [1:0]          mul_us;
    pe_saturation_mode_t saturate_mode;
    logic                red_en;
    logic                red_last;
`ifdef PE_RELU_EN
    logic                relu_en;
`endif
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out;
    logic                sat_flag;

    modport master (
        output in_valid, a, b, c, op, vsew, mul_us, saturate_mode, red_en, red_last,
`ifdef PE_RELU_EN
        output relu_en,
`endif
        output out_ready,
        input  in_ready, out_valid, out, sat_flag
    );

    modport slave (
        input  in_valid, a, b, c, op, vsew, mul_us, saturate_mode, red_en, red_last,
`ifdef PE_RELU_EN
        input  relu_en,
`endif
        input  out_ready,
        output in_ready, out_valid, out, sat_flag
    );
endinterface

// File: rtl/pe_pipe_acc.sv
// 3-stage pipelined lane PE (extend / compute+reduce / saturate+register) with valid/ready flow.
// Define PE_RELU_EN to add per-beat ReLU on the final result.
module pe_pipe_acc import pe_pipe_acc_pkg::*; #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 48
) (
    input logic         clk,
    input logic         n_reset,
    pe_pipe_acc_if.slave bus
);
    localparam int XW   = DATA_W + 1;
    localparam int SW   = 2 * XW;
    localparam int SEWW = 7;

    function automatic logic [SEWW-1:0] sew_of(input logic [1:0] v);
        logic [SEWW-1:0] s;
        case (v)
            2'd0:    s = 7'd8;
            2'd1:    s = 7'd16;
            2'd2:    s = 7'd32;
            2'd3:    s = (DATA_W == 64) ? 7'd64 : 7'd32;
            default: s = 7'd32;
        endcase
        return s;
    endfunction

    // Widen an element to XW bits, sign- or zero-extending from bit SEW-1.
    function automatic logic [XW-1:0] ext(input logic [DATA_W-1:0] v,
                                          input logic [SEWW-1:0]   s,
                                          input logic              uns);
        logic [XW-1:0] m;
        logic [XW-1:0] x;
        logic          sg;
        m  = (XW'(1'b1) << s) - XW'(1'b1);
        x  = {1'b0, v} & m;
        sg = |(x & (m ^ (m >> 1)));
        return (sg && !uns) ? (x | ~m) : x;
    endfunction

    function automatic logic [SW-1:0] sew_mask(input logic [SEWW-1:0] s);
        return (SW'(1'b1) << s) - SW'(1'b1);
    endfunction

    logic                en_s;
    logic [SEWW-1:0]     sew_in_s;
    logic                is_mul_s;
    logic                relu_in_s;

    // Stage 1 registers
    logic                v1_r;
    logic [XW-1:0]       a1_r, b1_r, c1_r;
    pe_arith_op_t        op1_r;
    pe_saturation_mode_t sm1_r;
    logic [SEWW-1:0]     sew1_r;
    logic                re1_r, rl1_r, relu1_r;

    // Stage 2 signals and registers
    logic signed [SW-1:0]    pa_s, pb_s, pc_s, prod_s, mterm_s, res_s;
    logic [SW-1:0]           mask1_s;
    logic [SEWW-1:0]         sh_s;
    logic signed [ACC_W-1:0] sum_s, acc_nxt_s, acc_r;
    logic                    dsat_s, emit_s;
    logic                    v2_r, dsat2_r, relu2_r;
    logic signed [SW-1:0]    res2_r;
    logic [SEWW-1:0]         sew2_r;

    // Stage 3 signals and registers
    logic [SW-1:0]        mask3_s;
    logic signed [SW-1:0] max_s, min_s, clamped_s, fin_s;
    logic                 sat_s;
    logic                 out_valid_r, sat_r;
    logic [DATA_W-1:0]    out_r;

    assign en_s         = !out_valid_r || bus.out_ready;
    assign bus.in_ready = en_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out       = out_r;
    assign bus.sat_flag  = sat_r;

    assign sew_in_s = sew_of(bus.vsew);
    assign is_mul_s = (bus.op == PE_MUL) || (bus.op == PE_MADD);
`ifdef PE_RELU_EN
    assign relu_in_s = bus.relu_en;
`else
    assign relu_in_s = 1'b0;
`endif

    // S1: capture the beat and extend operands to the element width.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            v1_r    <= 1'b0;
            a1_r    <= '0;
            b1_r    <= '0;
            c1_r    <= '0;
            op1_r   <= PE_ADD;
            sm1_r   <= PE_SAT_NONE;
            sew1_r  <= 7'd8;
            re1_r   <= 1'b0;
            rl1_r   <= 1'b0;
            relu1_r <= 1'b0;
        end else if (en_s) begin
            v1_r <= bus.in_valid;
            if (bus.in_valid) begin
                a1_r    <= ext(bus.a, sew_in_s, is_mul_s && !bus.red_en && bus.mul_us[1]);
                b1_r    <= ext(bus.b, sew_in_s, is_mul_s && bus.mul_us[0]);
                c1_r    <= ext(bus.c, sew_in_s, 1'b0);
                op1_r   <= bus.op;
                sm1_r   <= bus.saturate_mode;
                sew1_r  <= sew_in_s;
                re1_r   <= bus.red_en;
                rl1_r   <= bus.red_en && bus.red_last;
                relu1_r <= relu_in_s;
            end
        end
    end

    assign pa_s    = SW'($signed(a1_r));
    assign pb_s    = SW'($signed(b1_r));
    assign pc_s    = SW'($signed(c1_r));
    assign prod_s  = pa_s * pb_s;
    assign mterm_s = (sm1_r == PE_SAT_UPPER) ? (prod_s >>> (sew1_r - 7'd1)) : prod_s;
    assign mask1_s = sew_mask(sew1_r);
    assign sh_s    = b1_r[SEWW-1:0] & (sew1_r - 7'd1);
    assign sum_s   = acc_r + ACC_W'($signed(a1_r));

    // S2: arithmetic on the widened operands, or the reduction step.
    always_comb begin
        res_s     = '0;
        dsat_s    = 1'b0;
        emit_s    = v1_r;
        acc_nxt_s = acc_r;
        if (re1_r) begin
            res_s     = SW'(sum_s);
            dsat_s    = (sm1_r != PE_SAT_NONE);
            emit_s    = v1_r && rl1_r;
            acc_nxt_s = rl1_r ? '0 : sum_s;
        end else begin
            case (op1_r)
                PE_ADD:  begin res_s = pa_s + pb_s;    dsat_s = (sm1_r != PE_SAT_NONE); end
                PE_SUB:  begin res_s = pa_s - pb_s;    dsat_s = (sm1_r != PE_SAT_NONE); end
                PE_MUL:  begin res_s = mterm_s;        dsat_s = (sm1_r != PE_SAT_NONE); end
                PE_MADD: begin res_s = mterm_s + pc_s; dsat_s = (sm1_r != PE_SAT_NONE); end
                PE_SLL:  res_s = pa_s << sh_s;
                PE_SRL:  res_s = (pa_s & mask1_s) >> sh_s;
                PE_SRA:  res_s = pa_s >>> sh_s;
                PE_AND:  res_s = pa_s & pb_s;
                PE_OR:   res_s = pa_s | pb_s;
                PE_XOR:  res_s = pa_s ^ pb_s;
                default: begin res_s = '0; dsat_s = 1'b0; end
            endcase
        end
    end

    // Accumulator moves only when a reduction beat leaves S2.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            acc_r <= '0;
        end else if (en_s && v1_r && re1_r) begin
            acc_r <= acc_nxt_s;
        end
    end

    // S2 register: pre-saturation result.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            v2_r    <= 1'b0;
            res2_r  <= '0;
            dsat2_r <= 1'b0;
            sew2_r  <= 7'd8;
            relu2_r <= 1'b0;
        end else if (en_s) begin
            v2_r <= emit_s;
            if (emit_s) begin
                res2_r  <= res_s;
                dsat2_r <= dsat_s;
                sew2_r  <= sew1_r;
                relu2_r <= relu1_r;
            end
        end
    end

    assign mask3_s = sew_mask(sew2_r);
    assign max_s   = $signed(mask3_s >> 1);
    assign min_s   = ~max_s;

    // S3: signed clamp to SEW, truncate, then optional ReLU.
    always_comb begin
        clamped_s = res2_r;
        sat_s     = 1'b0;
        if (dsat2_r) begin
            if (res2_r > max_s) begin
                clamped_s = max_s;
                sat_s     = 1'b1;
            end else if (res2_r < min_s) begin
                clamped_s = min_s;
                sat_s     = 1'b1;
            end else begin
                clamped_s = res2_r;
            end
        end else begin
            sat_s = 1'b0;
        end
        fin_s = clamped_s & mask3_s;
        if (relu2_r && (|(fin_s & (mask3_s ^ (mask3_s >> 1))))) begin
            fin_s = '0;
        end else begin
            fin_s = clamped_s & mask3_s;
        end
    end

    // S3 register: output beat.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            out_valid_r <= 1'b0;
            out_r       <= '0;
            sat_r       <= 1'b0;
        end else if (en_s) begin
            out_valid_r <= v2_r;
            if (v2_r) begin
                out_r <= fin_s[DATA_W-1:0];
                sat_r <= sat_s;
            end
        end
    end
endmodule

// File: tb/tb_pe_pipe_acc.sv
// Directed self-checking bench for pe_pipe_acc (DATA_W=32); ReLU case runs when PE_RELU_EN is defined.
module tb_pe_pipe_acc;
    import pe_pipe_acc_pkg::*;

    logic clk = 1'b0;
    logic n_reset;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] got_q[$];
    logic        sat_q[$];

    pe_pipe_acc_if #(.DATA_W(32)) bus ();

    pe_pipe_acc #(.DATA_W(32), .ACC_W(48)) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            got_q.push_back(bus.out);
            sat_q.push_back(bus.sat_flag);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input pe_arith_op_t o, input logic [1:0] sew,
                          input pe_saturation_mode_t sm, input logic [1:0] us);
        bus.op = o;
        bus.vsew = sew;
        bus.saturate_mode = sm;
        bus.mul_us = us;
    endtask

    // One beat, then wait for it to emerge and check latency/result/flag.
    task automatic beat_chk(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] eo, input logic es);
        int n;
        bus.a = a;
        bus.b = b;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 10) begin
            step();
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'd3);
        chk({tag, "_out"}, 64'(bus.out), 64'(eo));
        chk({tag, "_sat"}, 64'(bus.sat_flag), 64'(es));
        step();
    endtask

    task automatic red_beat(input logic [31:0] a, input logic last);
        bus.a = a;
        bus.red_en = 1'b1;
        bus.red_last = last;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.red_en = 1'b0;
        bus.red_last = 1'b0;
    endtask

    initial begin
        int base;
        int sent;
        logic saw_stall;
        n_reset = 1'b0;
        bus.in_valid = 1'b0;
        bus.a = 32'd0;
        bus.b = 32'd0;
        bus.c = 32'd0;
        bus.red_en = 1'b0;
        bus.red_last = 1'b0;
        bus.out_ready = 1'b1;
`ifdef PE_RELU_EN
        bus.relu_en = 1'b0;
`endif
        set_op(PE_ADD, 2'd2, PE_SAT_NONE, 2'b00);
        #12;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out", 64'(bus.out), 64'd0);
        chk("rst_sat", 64'(bus.sat_flag), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        step();
        n_reset = 1'b1;
        step();

        set_op(PE_ADD, 2'd0, PE_SAT_LOWER, 2'b00);
        beat_chk("add8_sat", 32'h7F, 32'h01, 32'h0000007F, 1'b1);
        set_op(PE_ADD, 2'd0, PE_SAT_NONE, 2'b00);
        beat_chk("add8_wrap", 32'h7F, 32'h01, 32'h00000080, 1'b0);
        set_op(PE_SUB, 2'd0, PE_SAT_LOWER, 2'b00);
        beat_chk("sub8_sat", 32'h80, 32'h01, 32'h00000080, 1'b1);
        set_op(PE_MUL, 2'd2, PE_SAT_NONE, 2'b00);
        beat_chk("mul32", 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 1'b0);
        set_op(PE_MUL, 2'd1, PE_SAT_UPPER, 2'b00);
        beat_chk("mul16_frac", 32'h8000, 32'h8000, 32'h00007FFF, 1'b1);
        set_op(PE_MUL, 2'd1, PE_SAT_LOWER, 2'b11);
        beat_chk("mul16_uns", 32'hFFFF, 32'd2, 32'h00007FFF, 1'b1);
        set_op(PE_MUL, 2'd1, PE_SAT_LOWER, 2'b00);
        beat_chk("mul16_sgn", 32'hFFFF, 32'd2, 32'h0000FFFE, 1'b0);
        set_op(PE_SRL, 2'd0, PE_SAT_NONE, 2'b00);
        beat_chk("srl8", 32'h80, 32'h09, 32'h00000040, 1'b0);
        set_op(PE_SRA, 2'd0, PE_SAT_NONE, 2'b00);
        beat_chk("sra8", 32'h80, 32'h09, 32'h000000C0, 1'b0);
        set_op(PE_MADD, 2'd2, PE_SAT_NONE, 2'b00);
        bus.c = 32'd5;
        beat_chk("madd32", 32'd3, 32'd4, 32'd17, 1'b0);
        set_op(PE_RSVD, 2'd2, PE_SAT_LOWER, 2'b00);
        beat_chk("unsupported", 32'd5, 32'd5, 32'd0, 1'b0);
        set_op(PE_ADD, 2'd2, PE_SAT_NONE, 2'b00);
        bus.red_last = 1'b1;
        beat_chk("last_no_en", 32'd2, 32'd3, 32'd5, 1'b0);
        bus.red_last = 1'b0;

        // Reduction: one output per sum, accumulator restarts from zero.
        base = got_q.size();
        red_beat(32'd10, 1'b0);
        red_beat(32'd20, 1'b0);
        red_beat(32'd30, 1'b0);
        red_beat(32'd40, 1'b1);
        repeat (5) step();
        chk("red1_count", 64'(got_q.size() - base), 64'd1);
        if (got_q.size() > base) chk("red1_out", 64'(got_q[base]), 64'd100);
        base = got_q.size();
        red_beat(32'd1, 1'b0);
        red_beat(32'd2, 1'b1);
        repeat (5) step();
        chk("red2_count", 64'(got_q.size() - base), 64'd1);
        if (got_q.size() > base) chk("red2_out", 64'(got_q[base]), 64'd3);

        // Non-reduction beat in the middle of a reduction.
        base = got_q.size();
        red_beat(32'd7, 1'b0);
        bus.a = 32'd1;
        bus.b = 32'd1;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        red_beat(32'd3, 1'b1);
        repeat (5) step();
        chk("mix_count", 64'(got_q.size() - base), 64'd2);
        if (got_q.size() > base + 1) begin
            chk("mix_pass", 64'(got_q[base]), 64'd2);
            chk("mix_red", 64'(got_q[base + 1]), 64'd10);
        end

        // Saturated 8b reduction: 127 + 127 clamps.
        set_op(PE_ADD, 2'd0, PE_SAT_LOWER, 2'b00);
        base = got_q.size();
        red_beat(32'h7F, 1'b0);
        red_beat(32'h7F, 1'b1);
        repeat (5) step();
        chk("redsat_count", 64'(got_q.size() - base), 64'd1);
        if (got_q.size() > base) begin
            chk("redsat_out", 64'(got_q[base]), 64'h7F);
            chk("redsat_flag", 64'(sat_q[base]), 64'd1);
        end

        // Backpressure: out_ready low in cycles 2..5 of a 6-beat stream.
        set_op(PE_ADD, 2'd2, PE_SAT_NONE, 2'b00);
        base = got_q.size();
        sent = 0;
        saw_stall = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            bus.out_ready = !(cyc >= 2 && cyc <= 5);
            bus.in_valid = (sent < 6);
            bus.a = 32'(sent + 1);
            bus.b = 32'd100;
            #1;
            if (!bus.in_ready) saw_stall = 1'b1;
            if (bus.in_valid && bus.in_ready) sent++;
            step();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        chk("bp_stall_seen", 64'(saw_stall), 64'd1);
        chk("bp_sent", 64'(sent), 64'd6);
        chk("bp_count", 64'(got_q.size() - base), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (got_q.size() > base + i) chk($sformatf("bp_out%0d", i), 64'(got_q[base + i]), 64'(101 + i));
        end

        // Reset during a reduction discards it entirely.
        base = got_q.size();
        red_beat(32'd10, 1'b0);
        red_beat(32'd20, 1'b0);
        red_beat(32'd30, 1'b0);
        n_reset = 1'b0;
        #3;
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        step();
        n_reset = 1'b1;
        repeat (4) step();
        chk("midrst_no_out", 64'(got_q.size() - base), 64'd0);
        red_beat(32'd5, 1'b1);
        repeat (5) step();
        chk("midrst_count", 64'(got_q.size() - base), 64'd1);
        if (got_q.size() > base) chk("midrst_out", 64'(got_q[base]), 64'd5);

`ifdef PE_RELU_EN
        bus.relu_en = 1'b1;
        beat_chk("relu_neg", 32'hFFFFFFFC, 32'd0, 32'd0, 1'b0);
        beat_chk("relu_pos", 32'd4, 32'd3, 32'd7, 1'b0);
        bus.relu_en = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
